// File: rtl/pal_prog.sv
// Programmable 3-in/3-out PAL: serial fuse-map load with even parity, atomic commit, registered SOP outputs.
// Optional fuse readback port enabled by defining PAL_READBACK_EN.

module pal_sop #(
  parameter int TERMS = 3
) (
  input  logic [TERMS*6-1:0] fuses,
  input  logic [5:0]         lits,
  output logic               sop
);
  logic [TERMS-1:0] term;

  // A term with no fuses blown is tied off rather than evaluating to an empty AND (=1).
  for (genvar t = 0; t < TERMS; t++) begin : g_term
    assign term[t] = (|fuses[t*6 +: 6]) & (&(lits | ~fuses[t*6 +: 6]));
  end

  assign sop = |term;
endmodule

module pal_prog #(
  parameter int TERMS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic prog_start,
  input  logic prog_data,
  input  logic prog_valid,
  output logic prog_ready,
  output logic prog_done,
  output logic prog_err,
  output logic cfg_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic x,
  output logic y,
  output logic z
`ifdef PAL_READBACK_EN
  ,
  input  logic rb_start,
  output logic rb_data,
  output logic rb_valid
`endif
);
  localparam int TW = TERMS * 6;
  localparam int NF = 3 * TW;
  localparam int CW = $clog2(NF);

  typedef enum logic [1:0] {IDLE, LOAD, PARITY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [NF-1:0] shadow;
  logic [NF-1:0] active;
  logic          par;
  logic [5:0]    lits;
  logic [2:0]    sop;

  // Shadow shifts in from the top so fuse 0 ends up at bit 0 after NF beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      par        <= 1'b0;
      prog_ready <= 1'b0;
      prog_done  <= 1'b0;
      prog_err   <= 1'b0;
      cfg_valid  <= 1'b0;
    end else begin
      prog_done <= 1'b0;
      if (prog_start) begin
        state      <= LOAD;
        cnt        <= '0;
        shadow     <= '0;
        par        <= 1'b0;
        prog_err   <= 1'b0;
        prog_ready <= 1'b1;
      end else if (prog_ready && prog_valid) begin
        if (state == LOAD) begin
          shadow <= {prog_data, shadow[NF-1:1]};
          par    <= par ^ prog_data;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(NF - 1)) state <= PARITY;
        end else begin
          state      <= IDLE;
          prog_ready <= 1'b0;
          if (par ^ prog_data) begin
            prog_err <= 1'b1;
          end else begin
            active    <= shadow;
            cfg_valid <= 1'b1;
            prog_done <= 1'b1;
          end
        end
      end
    end
  end

  assign lits = {~c, c, ~b, b, ~a, a};

  for (genvar o = 0; o < 3; o++) begin : g_out
    pal_sop #(.TERMS(TERMS)) u_sop (
      .fuses (active[o*TW +: TW]),
      .lits  (lits),
      .sop   (sop[o])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= 1'b0;
      y <= 1'b0;
      z <= 1'b0;
    end else begin
      x <= sop[0];
      y <= sop[1];
      z <= sop[2];
    end
  end

`ifdef PAL_READBACK_EN
  localparam int RW = $clog2(NF + 2);

  logic [NF-1:0] rb_sh;
  logic [RW-1:0] rb_cnt;
  logic          rb_par;

  // Snapshot of the active array taken at rb_start, so a commit mid-readback does not tear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_sh    <= '0;
      rb_cnt   <= '0;
      rb_par   <= 1'b0;
      rb_data  <= 1'b0;
      rb_valid <= 1'b0;
    end else if (!rb_valid) begin
      if (rb_start && state == IDLE) begin
        rb_valid <= 1'b1;
        rb_data  <= active[0];
        rb_par   <= active[0];
        rb_sh    <= active >> 1;
        rb_cnt   <= RW'(1);
      end
    end else if (rb_cnt < RW'(NF)) begin
      rb_data <= rb_sh[0];
      rb_par  <= rb_par ^ rb_sh[0];
      rb_sh   <= rb_sh >> 1;
      rb_cnt  <= rb_cnt + 1'b1;
    end else if (rb_cnt == RW'(NF)) begin
      rb_data <= rb_par;
      rb_cnt  <= rb_cnt + 1'b1;
    end else begin
      rb_valid <= 1'b0;
      rb_data  <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_pal_prog.sv
// Bench for pal_prog: table-driven SOP sweeps through an expected-value queue plus load/abort/reset sequences.

module tb_pal_prog;
  localparam int NF = 54;

  typedef struct packed {
    logic [2:0] abc;
    logic [2:0] xyz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prog_start = 1'b0, prog_data = 1'b0, prog_valid = 1'b0;
  logic prog_ready, prog_done, prog_err, cfg_valid;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic x, y, z;
`ifdef PAL_READBACK_EN
  logic rb_start = 1'b0;
  logic rb_data, rb_valid;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [2:0] exp_q[$];

  pal_prog #(.TERMS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_start(prog_start), .prog_data(prog_data), .prog_valid(prog_valid),
    .prog_ready(prog_ready), .prog_done(prog_done), .prog_err(prog_err), .cfg_valid(cfg_valid),
    .a(a), .b(b), .c(c), .x(x), .y(y), .z(z)
`ifdef PAL_READBACK_EN
    , .rb_start(rb_start), .rb_data(rb_data), .rb_valid(rb_valid)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (prog_done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected xyz is queued when abc is driven and popped one cycle later when the output register has it.
  task automatic run_tab(input string nm, input vec_t t[8], input int n);
    for (int i = 0; i < n; i++) begin
      {a, b, c} = t[i].abc;
      exp_q.push_back(t[i].xyz);
      @(negedge clk);
      chk3($sformatf("%s abc=%b", nm, t[i].abc), {x, y, z}, exp_q.pop_front());
    end
  endtask

  task automatic pulse_start(input logic with_beat);
    prog_start = 1'b1;
    prog_valid = with_beat;
    prog_data  = 1'b1;
    @(negedge clk);
    prog_start = 1'b0;
    prog_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [NF-1:0] f, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i[0]) begin
        prog_valid = 1'b0;
        prog_data  = ~f[i];
        @(negedge clk);
      end
      prog_valid = 1'b1;
      prog_data  = f[i];
      @(negedge clk);
    end
    prog_valid = 1'b0;
  endtask

  task automatic send_par(input logic p);
    prog_valid = 1'b1;
    prog_data  = p;
    @(negedge clk);
    prog_valid = 1'b0;
  endtask

  logic [NF-1:0] m1, m2;
  vec_t t_zero[8], t_m1[8], t_m2[8];

  initial begin
    // Terms packed x0,x1,x2,y0,y1,y2,z0,z1,z2 from LSB; literal bits a,a_n,b,b_n,c,c_n.
    m1 = {6'b000000, 6'b011010, 6'b000101, 6'b011001, 6'b100010, 6'b000110,
          6'b000000, 6'b000000, 6'b000100};
    m2 = {6'b000000, 6'b000000, 6'b000000, 6'b100110, 6'b010001, 6'b011000,
          6'b000000, 6'b010100, 6'b101000};
    t_zero = '{'{3'b000,3'b000}, '{3'b001,3'b000}, '{3'b010,3'b000}, '{3'b011,3'b000},
               '{3'b100,3'b000}, '{3'b101,3'b000}, '{3'b110,3'b000}, '{3'b111,3'b000}};
    t_m1   = '{'{3'b000,3'b010}, '{3'b001,3'b001}, '{3'b010,3'b110}, '{3'b011,3'b110},
               '{3'b100,3'b000}, '{3'b101,3'b010}, '{3'b110,3'b101}, '{3'b111,3'b101}};
    t_m2   = '{'{3'b000,3'b100}, '{3'b101,3'b010}, '{3'b000,3'b000}, '{3'b000,3'b000},
               '{3'b000,3'b000}, '{3'b000,3'b000}, '{3'b000,3'b000}, '{3'b000,3'b000}};

    // Reset held: outputs stay 0 whatever abc does
    @(negedge clk);
    run_tab("rst_sweep", t_zero, 8);
    chk1("rst cfg_valid", cfg_valid, 1'b0);
    chk1("rst prog_ready", prog_ready, 1'b0);
    chk1("rst prog_err", prog_err, 1'b0);
    rst_n = 1'b1;
    run_tab("empty_sweep", t_zero, 8);
    chk1("empty cfg_valid", cfg_valid, 1'b0);

    // prog_valid in IDLE is ignored
    prog_valid = 1'b1;
    prog_data  = 1'b1;
    repeat (3) @(negedge clk);
    prog_valid = 1'b0;
    chk1("idle ready", prog_ready, 1'b0);

    // Good load of map 1; commit edge still uses the old (empty) map
    pulse_start(1'b0);
    chk1("load ready", prog_ready, 1'b1);
    send_beats(m1, NF, 1'b0);
    chk1("parity ready", prog_ready, 1'b1);
    chk1("no early done", prog_done, 1'b0);
    {a, b, c} = 3'b010;
    send_par(^m1);
    chk1("commit done", prog_done, 1'b1);
    chk1("commit cfg_valid", cfg_valid, 1'b1);
    chk1("commit err", prog_err, 1'b0);
    chk1("commit ready", prog_ready, 1'b0);
    chk3("commit edge old map", {x, y, z}, 3'b000);
    @(negedge clk);
    chk1("done one cycle", prog_done, 1'b0);
    chk3("new map next edge", {x, y, z}, 3'b110);
    chk_int("done count good", done_cnt, 1);
    run_tab("map1", t_m1, 8);

`ifdef PAL_READBACK_EN
    rb_start = 1'b1;
    @(negedge clk);
    rb_start = 1'b0;
    for (int i = 0; i <= NF; i++) begin
      logic eb;
      eb = (i < NF) ? m1[i] : ^m1;
      chk1($sformatf("rb_valid %0d", i), rb_valid, 1'b1);
      chk1($sformatf("rb_data %0d", i), rb_data, eb);
      @(negedge clk);
    end
    chk1("rb_valid end", rb_valid, 1'b0);
`endif

    // Bad parity on a different map: old map must survive
    pulse_start(1'b0);
    send_beats(m2, NF, 1'b0);
    send_par(~(^m2));
    chk1("bad par err", prog_err, 1'b1);
    chk1("bad par done", prog_done, 1'b0);
    chk1("bad par cfg_valid", cfg_valid, 1'b1);
    @(negedge clk);
    chk1("err sticky", prog_err, 1'b1);
    chk_int("done count bad", done_cnt, 1);
    run_tab("map1 kept", t_m1, 8);

    // Abort after 20 beats (restart carries an ignored beat), then gapped load of map 2
    pulse_start(1'b0);
    chk1("start clears err", prog_err, 1'b0);
    send_beats(m1, 20, 1'b0);
    pulse_start(1'b1);
    chk1("abort ready", prog_ready, 1'b1);
    send_beats(m2, NF, 1'b1);
    chk1("abort no done", prog_done, 1'b0);
    send_par(^m2);
    chk1("abort commit done", prog_done, 1'b1);
    @(negedge clk);
    chk_int("done count abort", done_cnt, 2);
    run_tab("map2", t_m2, 2);

    // Asynchronous reset mid-load clears everything
    {a, b, c} = 3'b000;
    @(negedge clk);
    chk3("pre-reset xyz", {x, y, z}, 3'b100);
    pulse_start(1'b0);
    send_beats(m1, 30, 1'b0);
    chk1("midload ready", prog_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk3("async rst xyz", {x, y, z}, 3'b000);
    chk1("async rst ready", prog_ready, 1'b0);
    chk1("async rst cfg_valid", cfg_valid, 1'b0);
    chk1("async rst done", prog_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send_beats(m1, 4, 1'b0);
    chk1("post rst idle", prog_ready, 1'b0);
    run_tab("cleared", t_zero, 8);
    chk1("cleared cfg_valid", cfg_valid, 1'b0);
    chk_int("done count reset", done_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
